halved_sample_fifo: RTL

- Buffers the 8-bit halved samples produced by the combinational divide-by-two stage; sits directly downstream of it.
- The divide-by-two output drives in_data. Upstream logic qualifies each sample with in_valid.
- The consumer drains samples through a valid/ready interface.
- Decouples the untimed combinational path from a back-pressured consumer. Reports occupancy and dropped samples.

---
 rtl/halved_sample_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/halved_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : halved_sample_fifo
// Purpose  : Buffers halved samples for a back-pressured valid/ready consumer,
//            reporting occupancy, almost_full and a sticky overflow flag.
// Option   : HALVED_SAMPLE_FIFO_PEAK_EN adds the peak_count output.
// Revision : 1.0
// ============================================================================
module halved_sample_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow
`ifdef HALVED_SAMPLE_FIFO_PEAK_EN
  ,
  output logic [$clog2(DEPTH):0]     peak_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             w_full, w_empty, w_wr_en, w_rd_en;

  // Full/empty come from the occupancy count, never from pointer equality.
  assign w_full  = (count_q == DEPTH_C);
  assign w_empty = (count_q == '0);
  assign w_wr_en = in_valid && !w_full;
  assign w_rd_en = out_ready && !w_empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (in_valid & w_full);
    if (w_wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (w_wr_en && !w_rd_en)      count_d = count_q + CW'(1);
    else if (!w_wr_en && w_rd_en) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; stale entries are masked by the empty check below.
  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready    = !w_full;
  assign out_valid   = !w_empty;
  assign out_data    = w_empty ? '0 : mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= AF_C);
  assign overflow    = overflow_q;

`ifdef HALVED_SAMPLE_FIFO_PEAK_EN
  logic [CW-1:0] peak_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else if (count_q > peak_q) begin
      peak_q <= count_q;
    end
  end

  assign peak_count = peak_q;
`endif

endmodule
`default_nettype wire
